// File: rtl/booth_mul_arbiter_if.sv
// Request/grant, multiplier-core and response signals shared between the
// two requesters, the Booth core and booth_mul_arbiter.
interface booth_mul_arbiter_if #(parameter int N = 8);
    logic           req0;
    logic           req1;
    logic [N-1:0]   m0;
    logic [N-1:0]   q0;
    logic [N-1:0]   m1;
    logic [N-1:0]   q1;
    logic           gnt0;
    logic           gnt1;
    logic           mul_start;
    logic [N-1:0]   mul_m;
    logic [N-1:0]   mul_q;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*N-1:0] rsp_prod;
    logic           rsp_err;
    logic           busy;

    modport slave (
        input  req0, req1, m0, q0, m1, q1, mul_done, mul_prod,
        output gnt0, gnt1, mul_start, mul_m, mul_q,
               rsp_valid, rsp_id, rsp_prod, rsp_err, busy
    );

    modport master (
        output req0, req1, m0, q0, m1, q1, mul_done, mul_prod,
        input  gnt0, gnt1, mul_start, mul_m, mul_q,
               rsp_valid, rsp_id, rsp_prod, rsp_err, busy
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier core between two requesters,
// with a bounded wait for the core and a timed-out error response.
module booth_mul_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_mul_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t         state_r, state_s;
    logic           gnt0_r, gnt0_s;
    logic           gnt1_r, gnt1_s;
    logic           start_r, start_s;
    logic [N-1:0]   mul_m_r, mul_m_s;
    logic [N-1:0]   mul_q_r, mul_q_s;
    logic           rsp_valid_r, rsp_valid_s;
    logic           rsp_id_r, rsp_id_s;
    logic [2*N-1:0] rsp_prod_r, rsp_prod_s;
    logic           rsp_err_r, rsp_err_s;
    logic           busy_r, busy_s;
    logic           owner_r, owner_s;
    logic           last_r, last_s;
    logic [7:0]     cnt_r, cnt_s;
    logic           win_s;

    // Next-state and next-output logic; every output is the registered image of these values.
    always_comb begin
        state_s     = state_r;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        start_s     = 1'b0;
        mul_m_s     = mul_m_r;
        mul_q_s     = mul_q_r;
        rsp_valid_s = 1'b0;
        rsp_id_s    = rsp_id_r;
        rsp_prod_s  = rsp_prod_r;
        rsp_err_s   = rsp_err_r;
        owner_s     = owner_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        // Under contention the requester not granted last wins; otherwise the sole requester.
        win_s       = (bus.req0 && bus.req1) ? ~last_r : bus.req1;

        case (state_r)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_s  = ~win_s;
                    gnt1_s  = win_s;
                    start_s = 1'b1;
                    mul_m_s = win_s ? bus.m1 : bus.m0;
                    mul_q_s = win_s ? bus.q1 : bus.q0;
                    owner_s = win_s;
                    last_s  = win_s;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s   = 8'd0;
                state_s = WAIT;
            end
            WAIT: begin
                // A done coinciding with the last allowed cycle still counts as completion.
                if (bus.mul_done) begin
                    rsp_prod_s  = bus.mul_prod;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_id_s    = owner_r;
                    state_s     = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    rsp_prod_s  = '0;
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = 1'b1;
                    rsp_id_s    = owner_r;
                    state_s     = RESP;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset points the round-robin pointer at requester 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            start_r     <= 1'b0;
            mul_m_r     <= '0;
            mul_q_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_prod_r  <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            cnt_r       <= 8'd0;
        end else begin
            state_r     <= state_s;
            gnt0_r      <= gnt0_s;
            gnt1_r      <= gnt1_s;
            start_r     <= start_s;
            mul_m_r     <= mul_m_s;
            mul_q_r     <= mul_q_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_id_r    <= rsp_id_s;
            rsp_prod_r  <= rsp_prod_s;
            rsp_err_r   <= rsp_err_s;
            busy_r      <= busy_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.mul_start = start_r;
    assign bus.mul_m     = mul_m_r;
    assign bus.mul_q     = mul_q_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_prod  = rsp_prod_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed-plus-random bench for booth_mul_arbiter: the bench plays both
// requesters and the multiplier core, and predicts winners and products itself.
module tb_booth_mul_arbiter;
    localparam int N  = 8;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic last  = 1'b1;   // model: requester granted most recently

    always #5 clk = ~clk;

    booth_mul_arbiter_if #(.N(N)) bus ();

    booth_mul_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.gnt0, bus.gnt1, bus.mul_start, bus.rsp_valid, bus.rsp_err,
                  bus.busy, bus.rsp_id}, 7'd0);
        chk({tag, "_data"}, {bus.mul_m, bus.mul_q, bus.rsp_prod}, 32'd0);
    endtask

    // One transaction starting in an IDLE cycle; core answers after 'delay' WAIT cycles
    // (never if delay >= TO). Ends in the following IDLE cycle.
    task automatic txn(input logic r0, input logic r1, input logic hold, input int delay,
                       input logic [N-1:0] a0, input logic [N-1:0] b0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1);
        logic           w;
        logic [N-1:0]   em, eq;
        logic [2*N-1:0] ep, xp;
        if (r0 && !bus.req0) begin bus.m0 = a0; bus.q0 = b0; end
        if (r1 && !bus.req1) begin bus.m1 = a1; bus.q1 = b1; end
        bus.req0 = r0;
        bus.req1 = r1;
        w    = (r0 && r1) ? ~last : r1;
        last = w;
        em   = w ? bus.m1 : bus.m0;
        eq   = w ? bus.q1 : bus.q0;
        ep   = smul(em, eq);
        xp   = (delay < TO) ? ep : '0;

        @(posedge clk); #1;
        chk("gnt0", bus.gnt0, !w);
        chk("gnt1", bus.gnt1, w);
        chk("mul_start", bus.mul_start, 1'b1);
        chk("mul_m", bus.mul_m, em);
        chk("mul_q", bus.mul_q, eq);
        chk("busy_issue", bus.busy, 1'b1);
        chk("rsp_valid_issue", bus.rsp_valid, 1'b0);
        if (!hold) begin
            if (w) bus.req1 = 1'b0;
            else   bus.req0 = 1'b0;
        end

        @(posedge clk); #1;
        for (int i = 0; i < TO; i++) begin
            chk("wait_quiet", {bus.rsp_valid, bus.gnt0, bus.gnt1, bus.mul_start}, 4'd0);
            chk("wait_busy", bus.busy, 1'b1);
            chk("wait_operands", {bus.mul_m, bus.mul_q}, {em, eq});
            bus.mul_done = (i == delay);
            bus.mul_prod = (i == delay) ? ep : ~ep;
            @(posedge clk); #1;
            bus.mul_done = 1'b0;
            if (i == delay || i == TO - 1) begin
                chk("rsp_valid", bus.rsp_valid, 1'b1);
                chk("rsp_id", bus.rsp_id, w);
                chk("rsp_prod", bus.rsp_prod, xp);
                chk("rsp_err", bus.rsp_err, (delay >= TO));
                chk("busy_resp", bus.busy, 1'b1);
                break;
            end
        end

        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_pulses", {bus.rsp_valid, bus.gnt0, bus.gnt1, bus.mul_start}, 4'd0);
        chk("rsp_hold", {bus.rsp_prod, bus.rsp_id}, {xp, w});
    endtask

    initial begin
        logic r0, r1;
        int   d;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.m0 = '0; bus.q0 = '0; bus.m1 = '0; bus.q1 = '0;
        bus.mul_done = 1'b0; bus.mul_prod = '0;

        // Reset state, with both requesters already waiting
        repeat (2) @(posedge clk); #1;
        bus.m0 = N'($urandom); bus.q0 = N'($urandom);
        bus.m1 = N'($urandom); bus.q1 = N'($urandom);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        rst_n = 1'b1;

        // Contention held continuously: grants alternate starting with requester 0
        for (int k = 0; k < 4; k++) begin
            txn(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 10)),
                N'($urandom), N'($urandom), N'($urandom), N'($urandom));
            chk("rr_order", bus.rsp_id, k[0]);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk); #1;
        chk("no_req_idle", {bus.busy, bus.gnt0, bus.gnt1}, 3'd0);

        // Single request, unsigned example
        txn(1'b1, 1'b0, 1'b0, 7, 8'd31, 8'd39, 8'd0, 8'd0);
        chk("ex_prod", bus.rsp_prod, 16'h04B9);
        chk("ex_id_err", {bus.rsp_id, bus.rsp_err}, 2'b00);

        // Signed operands from requester 1
        txn(1'b0, 1'b1, 1'b0, 5, 8'd0, 8'd0, 8'hFB, 8'h07);
        chk("signed_prod", bus.rsp_prod, 16'hFFDD);
        chk("signed_id", bus.rsp_id, 1'b1);

        // Timeout, then a late done that must be ignored
        txn(1'b1, 1'b0, 1'b0, 1000, N'($urandom), N'($urandom), 8'd0, 8'd0);
        chk("timeout_err", bus.rsp_err, 1'b1);
        chk("timeout_prod", bus.rsp_prod, 16'd0);
        bus.mul_done = 1'b1;
        bus.mul_prod = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("late_done", {bus.rsp_valid, bus.busy, bus.rsp_err}, 3'b001);
        end
        bus.mul_done = 1'b0;

        // Done coincides with the final WAIT cycle
        txn(1'b0, 1'b1, 1'b0, TO - 1, 8'd0, 8'd0, N'($urandom), N'($urandom));
        chk("edge_err", bus.rsp_err, 1'b0);

        // Randomized traffic; a requester left pending keeps its request up
        for (int k = 0; k < 10; k++) begin
            r0 = 1'($urandom_range(0, 1)) | bus.req0;
            r1 = (r0 ? 1'($urandom_range(0, 1)) : 1'b1) | bus.req1;
            d  = ($urandom_range(0, 7) == 0) ? TO + 5 : int'($urandom_range(0, 12));
            txn(r0, r1, 1'b0, d, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of WAIT abandons the transaction
        bus.m1 = N'($urandom); bus.q1 = N'($urandom);
        bus.req1 = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_gnt1", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwait_rst");
        bus.mul_done = 1'b1;
        bus.mul_prod = 16'h5A5A;
        repeat (2) @(posedge clk); #1;
        chk_all_zero("midwait_rst_held");
        bus.mul_done = 1'b0;
        rst_n = 1'b1;
        last  = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_quiet", {bus.rsp_valid, bus.busy}, 2'd0);
        txn(1'b0, 1'b1, 1'b0, 3, 8'd0, 8'd0, N'($urandom), N'($urandom));
        txn(1'b1, 1'b1, 1'b0, 2, N'($urandom), N'($urandom), N'($urandom), N'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter N, default 8: operand width in bits; product width is 2N.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT-state cycles before the transaction is abandoned; legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1 each  requester 0/1 request; held high until its gnt pulse.
REQ-006 m0, q0 / m1, q1  input  N each  signed multiplicand/multiplier of requester 0/1; stable while its req is high.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: operands accepted, requester may drop req.
REQ-008 mul_start  output  1  one-cycle start pulse to the shared Booth multiplier core.
REQ-009 mul_m, mul_q  output  N each  registered operands driven to the core; stable from ISSUE until return to IDLE.
REQ-010 mul_done  input  1  core completion strobe; sampled only in WAIT.
REQ-011 mul_prod  input  2N  core signed product; valid when mul_done is high.
REQ-012 rsp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_prod  output  2N  product returned with rsp_valid.
REQ-015 rsp_err  output  1  high with rsp_valid when the transaction timed out.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-018 IDLE: if req0 or req1 is high at an edge, the winner's operands are latched into mul_m/mul_q, owner id is recorded, the winner's gnt is high for the following cycle only, and the next state is ISSUE; otherwise remain in IDLE.
REQ-019 Arbitration: round-robin; with both requests high, the requester not granted last wins; with one request, that one wins regardless of history.
REQ-020 ISSUE: mul_start is high for exactly this one cycle; the WAIT cycle counter is cleared; the next state is WAIT.
REQ-021 WAIT: the counter increments each cycle; mul_done high -> capture mul_prod into rsp_prod, rsp_err=0, next state RESP.
REQ-022 Timeout: counter reaches TIMEOUT-1 with mul_done low -> rsp_prod=0, rsp_err=1, next state RESP; mul_done in the same cycle as the timeout takes precedence (normal completion).
REQ-023 RESP: rsp_valid is high for this one cycle with rsp_id=owner; the next state is IDLE.
REQ-024 Minimum latency: req sampled at edge k -> gnt cycle k+1 (ISSUE), WAIT from k+2; mul_done seen at edge j -> rsp_valid in cycle j+1.
REQ-025 Requests arriving outside IDLE are not granted; they are evaluated at the first IDLE edge.
REQ-026 Back-to-back operation: a request pending on return to IDLE is granted at the next edge; there is no idle bubble beyond the single IDLE cycle.
REQ-027 mul_done outside WAIT is ignored; a late done after a timeout produces no response.
REQ-028 rsp_prod and rsp_err hold their values until the next RESP; rsp_id likewise.

Reset
REQ-029 rst_n low immediately forces: state IDLE, gnt0=gnt1=0, mul_start=0, rsp_valid=0, rsp_err=0, busy=0, mul_m=mul_q=0, rsp_prod=0, rsp_id=0, counter=0.
REQ-030 Reset sets the last-granted pointer to requester 1, so requester 0 wins the first contended arbitration.
REQ-031 Reset asserted mid-transaction abandons the transaction with no response; the pending requester must re-request.

Verification
REQ-032 Single request: req0, m0=8'd31, q0=8'd39, core returns 16'd1209 after 8 cycles -> gnt0 pulse, mul_start pulse with mul_m=31/mul_q=39, rsp_valid with rsp_id=0, rsp_prod=16'h04B9, rsp_err=0.
REQ-033 Contention: req0 and req1 held high continuously from reset release -> grants alternate 0,1,0,1; each rsp_id matches its grant order.
REQ-034 Signed operands: m1=-8'sd5, q1=8'sd7, core returns -35 -> rsp_id=1, rsp_prod=16'hFFDD.
REQ-035 Timeout: core never asserts mul_done, TIMEOUT=64 -> rsp_valid after 64 WAIT cycles with rsp_err=1, rsp_prod=0; a later mul_done pulse produces no response.
REQ-036 Reset mid-WAIT: rst_n low for 2 cycles during WAIT -> all outputs zero at once, no rsp_valid; after release, req1 alone is granted normally.
REQ-037 Simultaneous done and timeout in the final WAIT cycle -> rsp_err=0 and rsp_prod equals mul_prod.
